// File: rtl/boot_loader_if.sv
// boot_loader_if: byte-stream, cmem write and core-control signals of the program loader.
//   InData/InValid/InReady          : byte stream handshake (transfer when InValid && InReady)
//   MemWriteEnable/MemAddress/...   : one-cycle cmem word write
//   CoreStart/CoreDone              : core launch pulse and completion
//   Busy/Error                      : loader status
// slave  : loader side (boot_loader)
// master : environment side (byte source, cmem, core)
interface boot_loader_if #(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8
);
    logic [7:0]            InData;
    logic                  InValid;
    logic                  InReady;
    logic                  MemWriteEnable;
    logic [ADDR_WIDTH-1:0] MemAddress;
    logic [WORD_WIDTH-1:0] MemWriteData;
    logic                  CoreStart;
    logic                  CoreDone;
    logic                  Busy;
    logic                  Error;

    modport slave (
        input  InData, InValid, CoreDone,
        output InReady, MemWriteEnable, MemAddress, MemWriteData, CoreStart, Busy, Error
    );

    modport master (
        output InData, InValid, CoreDone,
        input  InReady, MemWriteEnable, MemAddress, MemWriteData, CoreStart, Busy, Error
    );
endinterface

// File: rtl/boot_loader.sv
// boot_loader: receives a framed byte stream (16-bit LE word count, payload words LE, XOR
// checksum), writes the assembled words to cmem from address 0 upward, launches the core on a
// good frame and re-arms once the core reports done. A bad frame parks in a sticky error state.
//   Clock        : rising-edge clock
//   PowerOnReset : asynchronous active-low reset
//   bus          : boot_loader_if.slave (stream, cmem write, core control, status)
module boot_loader #(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input logic          Clock,
    input logic          PowerOnReset,
    boot_loader_if.slave bus
);
    localparam int unsigned BPW      = WORD_WIDTH / 8;
    localparam int unsigned BCW      = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [16:0] MaxWords = 17'(1) << ADDR_WIDTH;

    typedef enum logic [2:0] {
        StLen0, StLen1, StData, StCsum, StStart, StRun, StError
    } state_e;

    state_e                state_q, state_d;
    logic                  armed_q;
    logic [15:0]           n_q, n_d;
    logic [16:0]           word_cnt_q, word_cnt_d;
    logic [BCW-1:0]        byte_cnt_q, byte_cnt_d;
    logic [WORD_WIDTH-1:0] asm_q, asm_d;
    logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            xor_q, xor_d;
    logic                  in_ready;
    logic                  accept;

    // armed_q keeps InReady low until the first edge after reset release.
    assign in_ready = armed_q &&
                      (state_q == StLen0 || state_q == StLen1 ||
                       state_q == StData || state_q == StCsum);
    assign accept   = bus.InValid && in_ready;

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        wdata_d    = wdata_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        xor_d      = xor_q;

        // Address advances on the edge that ends the write strobe cycle.
        if (we_q) begin
            addr_d = addr_q + ADDR_WIDTH'(1);
        end

        unique case (state_q)
            StLen0: begin
                if (accept) begin
                    n_d[7:0] = bus.InData;
                    state_d  = StLen1;
                end
            end
            StLen1: begin
                if (accept) begin
                    n_d[15:8] = bus.InData;
                    if ({1'b0, bus.InData, n_q[7:0]} > MaxWords) begin
                        state_d = StError;
                    end else if ({bus.InData, n_q[7:0]} == 16'd0) begin
                        state_d = StCsum;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    // First byte of a word ends up in bits [7:0].
                    asm_d = (asm_q >> 8) | (WORD_WIDTH'(bus.InData) << (WORD_WIDTH - 8));
                    xor_d = xor_q ^ bus.InData;
                    if (byte_cnt_q == BCW'(BPW - 1)) begin
                        byte_cnt_d = '0;
                        wdata_d    = asm_d;
                        we_d       = 1'b1;
                        word_cnt_d = word_cnt_q + 17'd1;
                        if (word_cnt_d == {1'b0, n_q}) begin
                            state_d = StCsum;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + BCW'(1);
                    end
                end
            end
            StCsum: begin
                if (accept) begin
                    state_d = (bus.InData == xor_q) ? StStart : StError;
                end
            end
            StStart: begin
                state_d = StRun;
            end
            StRun: begin
                if (bus.CoreDone) begin
                    state_d    = StLen0;
                    xor_d      = '0;
                    word_cnt_d = '0;
                    byte_cnt_d = '0;
                    addr_d     = '0;
                end
            end
            StError: begin
                state_d = StError;
            end
            default: begin
                state_d = StError;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge PowerOnReset) begin
        if (!PowerOnReset) begin
            state_q    <= StLen0;
            armed_q    <= 1'b0;
            n_q        <= '0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            asm_q      <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            xor_q      <= '0;
        end else begin
            state_q    <= state_d;
            armed_q    <= 1'b1;
            n_q        <= n_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            xor_q      <= xor_d;
        end
    end

    assign bus.InReady        = in_ready;
    assign bus.MemWriteEnable = we_q;
    assign bus.MemAddress     = addr_q;
    assign bus.MemWriteData   = wdata_q;
    assign bus.CoreStart      = (state_q == StStart);
    assign bus.Busy           = (state_q != StLen0);
    assign bus.Error          = (state_q == StError);
endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: directed frames against boot_loader; write and start monitor on the falling edge.
module tb_boot_loader;
    localparam int unsigned WW = 32;
    localparam int unsigned AW = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    boot_loader_if #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW)) bus ();

    boot_loader #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW)) dut (
        .Clock        (clk),
        .PowerOnReset (rst_n),
        .bus          (bus)
    );

    int          n_vec = 0;
    int          n_bad = 0;
    int unsigned cyc   = 0;
    int unsigned last_acc = 0;
    logic [7:0]  pl[$];
    int unsigned exp_cyc[$];

    // Monitor-owned records
    logic [AW-1:0] wr_addr[$];
    logic [WW-1:0] wr_data[$];
    int unsigned   wr_cyc[$];
    int            start_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.MemWriteEnable) begin
            wr_addr.push_back(bus.MemAddress);
            wr_data.push_back(bus.MemWriteData);
            wr_cyc.push_back(cyc);
        end
        if (bus.CoreStart) start_cnt++;
    end

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int w;
        bus.InData  = b;
        bus.InValid = 1'b1;
        w = 0;
        @(negedge clk);
        while (!bus.InReady && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!bus.InReady) begin
            n_vec++;
            n_bad++;
            $display("FAIL accept_timeout byte=%02h: InReady=0, required 1", b);
            bus.InValid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        last_acc    = cyc;
        bus.InValid = 1'b0;
        if (gap) begin
            bus.InData = 8'hff;  // garbage while InValid is low
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_header(input logic [15:0] n, input bit gap);
        send_byte(n[7:0], gap);
        send_byte(n[15:8], gap);
    endtask

    task automatic send_payload(input bit gap);
        exp_cyc.delete();
        for (int i = 0; i < pl.size(); i++) begin
            send_byte(pl[i], gap);
            if (i % 4 == 3) exp_cyc.push_back(last_acc);
        end
    endtask

    task automatic wait_start(output bit seen, output int unsigned at);
        seen = 1'b0;
        at   = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.CoreStart) begin
                seen = 1'b1;
                at   = cyc;
            end
        end
    endtask

    task automatic finish_core();
        bus.CoreDone = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.CoreDone = 1'b0;
    endtask

    task automatic do_reset();
        bus.InValid  = 1'b0;
        bus.CoreDone = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.InData = 8'h00; bus.InValid = 1'b0; bus.CoreDone = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({bus.InReady, bus.MemWriteEnable, bus.CoreStart, bus.Busy, bus.Error} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b, required 00000",
                     {bus.InReady, bus.MemWriteEnable, bus.CoreStart, bus.Busy, bus.Error});
        end
        n_vec++;
        if (bus.MemAddress !== '0 || bus.MemWriteData !== '0) begin
            n_bad++;
            $display("FAIL reset_mem: addr=%h data=%h, required 0/0", bus.MemAddress,
                     bus.MemWriteData);
        end
        rst_n = 1'b1;
        #1;
        n_vec++;
        if (bus.InReady !== 1'b0) begin
            n_bad++;
            $display("FAIL ready_before_edge: got %b, required 0", bus.InReady);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (bus.InReady !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_after_edge: got %b, required 1", bus.InReady);
        end
    endtask

    task automatic run_two_word_frame(input bit gap, input string tag);
        int          wb;
        int          sb;
        bit          seen;
        int unsigned at;
        logic [AW-1:0] ea[2];
        logic [WW-1:0] ed[2];
        ea[0] = 8'd0; ed[0] = 32'h44332211;
        ea[1] = 8'd1; ed[1] = 32'h88776655;
        wb = wr_addr.size();
        sb = start_cnt;
        pl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        send_header(16'd2, gap);
        send_payload(gap);
        send_byte(8'h88, 1'b0);
        wait_start(seen, at);
        n_vec++;
        if (!seen || at != last_acc) begin
            n_bad++;
            $display("FAIL %s_start: seen=%0d cycle=%0d, required seen=1 cycle=%0d", tag, seen,
                     at, last_acc);
        end
        n_vec++;
        if (wr_addr.size() - wb != 2) begin
            n_bad++;
            $display("FAIL %s_write_count: got %0d, required 2", tag, wr_addr.size() - wb);
        end else begin
            for (int k = 0; k < 2; k++) begin
                n_vec++;
                if (wr_addr[wb+k] !== ea[k] || wr_data[wb+k] !== ed[k] ||
                    wr_cyc[wb+k] != exp_cyc[k]) begin
                    n_bad++;
                    $display("FAIL %s_write%0d: addr=%h data=%h cyc=%0d, required %h %h %0d",
                             tag, k, wr_addr[wb+k], wr_data[wb+k], wr_cyc[wb+k], ea[k], ed[k],
                             exp_cyc[k]);
                end
            end
        end
        @(negedge clk);
        n_vec++;
        if (bus.InReady !== 1'b0 || bus.Busy !== 1'b1 || start_cnt - sb != 1) begin
            n_bad++;
            $display("FAIL %s_run: ready=%b busy=%b starts=%0d, required 0 1 1", tag,
                     bus.InReady, bus.Busy, start_cnt - sb);
        end
    endtask

    task automatic test_stream();
        run_two_word_frame(1'b0, "stream");
        // In RUN: the edge sampling CoreDone returns to LEN0; a second high edge is ignored.
        bus.CoreDone = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (bus.InReady !== 1'b1 || bus.Busy !== 1'b0) begin
            n_bad++;
            $display("FAIL done_return: ready=%b busy=%b, required 1 0", bus.InReady, bus.Busy);
        end
        @(posedge clk);
        #1;
        bus.CoreDone = 1'b0;
        n_vec++;
        if (bus.Busy !== 1'b0 || bus.CoreStart !== 1'b0) begin
            n_bad++;
            $display("FAIL done_ignored: busy=%b start=%b, required 0 0", bus.Busy,
                     bus.CoreStart);
        end
    endtask

    task automatic test_toggle();
        run_two_word_frame(1'b1, "toggle");
        finish_core();
    endtask

    task automatic test_bad_csum();
        int wb;
        int sb;
        wb = wr_addr.size();
        sb = start_cnt;
        pl = '{8'h01, 8'h02, 8'h03, 8'h04};
        send_header(16'd1, 1'b0);
        send_payload(1'b0);
        send_byte(8'h00, 1'b0);
        repeat (8) @(negedge clk);
        n_vec++;
        if (bus.Error !== 1'b1 || bus.InReady !== 1'b0 || start_cnt - sb != 0) begin
            n_bad++;
            $display("FAIL bad_csum_state: err=%b ready=%b starts=%0d, required 1 0 0",
                     bus.Error, bus.InReady, start_cnt - sb);
        end
        n_vec++;
        if (wr_addr.size() - wb != 1) begin
            n_bad++;
            $display("FAIL bad_csum_writes: got %0d, required 1", wr_addr.size() - wb);
        end else if (wr_addr[wb] !== 8'd0 || wr_data[wb] !== 32'h04030201) begin
            n_bad++;
            $display("FAIL bad_csum_word: addr=%h data=%h, required 00 04030201", wr_addr[wb],
                     wr_data[wb]);
        end
        do_reset();
    endtask

    task automatic test_oversize();
        int wb;
        wb = wr_addr.size();
        send_header(16'h0101, 1'b0);
        @(negedge clk);
        n_vec++;
        if (bus.Error !== 1'b1 || bus.InReady !== 1'b0) begin
            n_bad++;
            $display("FAIL oversize_error: err=%b ready=%b, required 1 0", bus.Error,
                     bus.InReady);
        end
        repeat (4) @(negedge clk);
        n_vec++;
        if (wr_addr.size() - wb != 0) begin
            n_bad++;
            $display("FAIL oversize_writes: got %0d, required 0", wr_addr.size() - wb);
        end
        do_reset();
    endtask

    task automatic test_empty();
        int          wb;
        bit          seen;
        int unsigned at;
        wb = wr_addr.size();
        send_header(16'd0, 1'b0);
        send_byte(8'h00, 1'b0);
        wait_start(seen, at);
        n_vec++;
        if (!seen || at != last_acc || wr_addr.size() - wb != 0) begin
            n_bad++;
            $display("FAIL empty_frame: seen=%0d cyc=%0d writes=%0d, required 1 %0d 0", seen, at,
                     wr_addr.size() - wb, last_acc);
        end
        finish_core();
    endtask

    task automatic test_full();
        int          wb;
        bit          seen;
        int unsigned at;
        logic [7:0]  cs;
        logic [WW-1:0] ew;
        wb = wr_addr.size();
        pl.delete();
        cs = 8'h00;
        for (int i = 0; i < 1024; i++) begin
            pl.push_back(8'(i * 7 + 3));
            cs = cs ^ 8'(i * 7 + 3);
        end
        send_header(16'h0100, 1'b0);
        send_payload(1'b0);
        send_byte(cs, 1'b0);
        wait_start(seen, at);
        n_vec++;
        if (!seen) begin
            n_bad++;
            $display("FAIL full_start: seen=0, required 1");
        end
        n_vec++;
        if (wr_addr.size() - wb != 256) begin
            n_bad++;
            $display("FAIL full_write_count: got %0d, required 256", wr_addr.size() - wb);
        end else begin
            for (int k = 0; k < 256; k++) begin
                ew = {pl[4*k+3], pl[4*k+2], pl[4*k+1], pl[4*k]};
                n_vec++;
                if (wr_addr[wb+k] !== 8'(k) || wr_data[wb+k] !== ew) begin
                    n_bad++;
                    $display("FAIL full_write%0d: addr=%h data=%h, required %h %h", k,
                             wr_addr[wb+k], wr_data[wb+k], 8'(k), ew);
                end
            end
        end
        finish_core();
        // After the wrap the next frame must start at address 0 again.
        wb = wr_addr.size();
        pl = '{8'hde, 8'had, 8'hbe, 8'hef};
        send_header(16'd1, 1'b0);
        send_payload(1'b0);
        send_byte(8'h22, 1'b0);
        wait_start(seen, at);
        n_vec++;
        if (!seen || wr_addr.size() - wb != 1) begin
            n_bad++;
            $display("FAIL rearm_frame: seen=%0d writes=%0d, required 1 1", seen,
                     wr_addr.size() - wb);
        end else if (wr_addr[wb] !== 8'd0 || wr_data[wb] !== 32'hefbeadde) begin
            n_bad++;
            $display("FAIL rearm_word: addr=%h data=%h, required 00 efbeadde", wr_addr[wb],
                     wr_data[wb]);
        end
        finish_core();
    endtask

    task automatic test_mid_reset();
        int          wb;
        bit          seen;
        int unsigned at;
        pl.delete();
        for (int i = 0; i < 10; i++) pl.push_back(8'(8'h30 + i));
        send_header(16'd4, 1'b0);
        send_payload(1'b0);  // two full words plus two bytes of the third
        #1;
        n_vec++;
        if (bus.MemAddress !== 8'd2 || bus.Busy !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_pre_reset: addr=%h busy=%b, required 02 1", bus.MemAddress,
                     bus.Busy);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({bus.InReady, bus.MemWriteEnable, bus.CoreStart, bus.Busy, bus.Error} !== 5'b0 ||
            bus.MemAddress !== '0 || bus.MemWriteData !== '0) begin
            n_bad++;
            $display("FAIL mid_reset_outputs: flags=%b addr=%h data=%h, required 00000 00 0",
                     {bus.InReady, bus.MemWriteEnable, bus.CoreStart, bus.Busy, bus.Error},
                     bus.MemAddress, bus.MemWriteData);
        end
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        wb = wr_addr.size();
        pl = '{8'ha1, 8'ha2, 8'ha3, 8'ha4};
        send_header(16'd1, 1'b0);
        send_payload(1'b0);
        send_byte(8'h04, 1'b0);
        wait_start(seen, at);
        n_vec++;
        if (!seen || wr_addr.size() - wb != 1) begin
            n_bad++;
            $display("FAIL post_reset_frame: seen=%0d writes=%0d, required 1 1", seen,
                     wr_addr.size() - wb);
        end else if (wr_addr[wb] !== 8'd0 || wr_data[wb] !== 32'ha4a3a2a1) begin
            n_bad++;
            $display("FAIL post_reset_word: addr=%h data=%h, required 00 a4a3a2a1",
                     wr_addr[wb], wr_data[wb]);
        end
        finish_core();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_toggle();
        test_bad_csum();
        test_oversize();
        test_empty();
        test_full();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
